// File: rtl/sram_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache in front of the SRAM controller.
// Define CACHE_STATS_EN to add the hit_count/miss_count statistics outputs.
module sram_cache_controller #(
    parameter int INDEX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_en,
    input  logic        write_en,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic        sram_read_en,
    output logic        sram_write_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_writeData,
    input  logic [31:0] sram_readData,
    input  logic        sram_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int TAG_W = 17 - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, READ_MISS, WRITE_THRU} state_e;

    state_e             state_q, state_d;
    logic               rd_en_q, rd_en_d;
    logic               wr_en_q, wr_en_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [31:0]        data_mem [LINES];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic               fill;
    logic               update;
    logic               unused_addr_bits;

    assign idx              = address[INDEX_W+1:2];
    assign tag              = address[18:INDEX_W+2];
    assign hit              = valid_q[idx] && (tag_mem[idx] == tag);
    assign unused_addr_bits = ^{address[31:19], address[1:0]};

    assign sram_read_en   = rd_en_q;
    assign sram_write_en  = wr_en_q;
    assign sram_address   = address;
    assign sram_writeData = writeData;

    // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        rd_en_d  = rd_en_q;
        wr_en_d  = wr_en_q;
        ready    = 1'b1;
        readData = '0;
        fill     = 1'b0;
        update   = 1'b0;
        case (state_q)
            IDLE: begin
                if (write_en) begin
                    ready   = 1'b0;
                    state_d = WRITE_THRU;
                    wr_en_d = 1'b1;
                end else if (read_en) begin
                    if (hit) begin
                        readData = data_mem[idx];
                    end else begin
                        ready   = 1'b0;
                        state_d = READ_MISS;
                        rd_en_d = 1'b1;
                    end
                end
            end
            READ_MISS: begin
                ready = sram_ready;
                if (sram_ready) begin
                    readData = sram_readData;
                    fill     = 1'b1;
                    state_d  = IDLE;
                    rd_en_d  = 1'b0;
                end
            end
            WRITE_THRU: begin
                ready = sram_ready;
                if (sram_ready) begin
                    update  = hit;
                    state_d = IDLE;
                    wr_en_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        if (fill) valid_d[idx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            valid_q <= valid_d;
        end
    end

    // NOTE: tag/data arrays are not reset; clearing the valid bits is enough to make them unreachable.
    always_ff @(posedge clk) begin
        if (rst && (fill || update)) data_mem[idx] <= fill ? sram_readData : writeData;
        if (rst && fill) tag_mem[idx] <= tag;
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == IDLE && read_en && !write_en) begin
            if (hit) hit_count_d  = hit_count_q + 32'd1;
            else     miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
